// File: rtl/amm2lb_pkg.sv
// Shared types and constants for the Avalon-MM to local-bus bridge.
package amm2lb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/amm2lb.sv
// Avalon-MM slave to simple local register bus bridge, one transaction in flight,
// with an ack timeout so a silent local slave cannot hang the master.
module amm2lb
  import amm2lb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read_s,
  input  logic              write_s,
  input  logic [DATA_W-1:0] writedata,
  input  logic [STRB_W-1:0] byteenable,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  output logic [ADDR_W-1:0] lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic [STRB_W-1:0] lb_wstrb,
  output logic              lb_wen,
  input  logic              lb_wready,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid,
  output logic              err,
  output state_t            dbg_state
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  // Handshake: the master's request is taken on any rising edge where read_s or
  // write_s is high while waitrequest is low; local acks count only while the
  // matching lb_wen/lb_ren is high.
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_wen;
  logic                r_ren;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rdv;
  logic                r_err;
  logic                w_timeout;

  // The counter holds TIMEOUT-1 on the TIMEOUT-th cycle the request is up.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_wen   <= 1'b0;
      r_ren   <= 1'b0;
      r_rdata <= '0;
      r_rdv   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_rdv <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (write_s) begin
            r_addr  <= address;
            r_wdata <= writedata;
            r_wstrb <= byteenable;
            r_wen   <= 1'b1;
            r_state <= WR;
            // A read colliding with a write is answered with error data at once.
            if (read_s) begin
              r_err   <= 1'b1;
              r_rdv   <= 1'b1;
              r_rdata <= ERR_DATA;
            end
          end else if (read_s) begin
            r_addr  <= address;
            r_ren   <= 1'b1;
            r_state <= RD;
          end
        end
        WR: begin
          if (lb_wready) begin
            r_wen   <= 1'b0;
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_wen   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RD: begin
          if (lb_rvalid) begin
            r_rdata <= lb_rdata;
            r_rdv   <= 1'b1;
            r_ren   <= 1'b0;
            r_state <= IDLE;
          end else if (w_timeout) begin
            r_rdata <= ERR_DATA;
            r_rdv   <= 1'b1;
            r_err   <= 1'b1;
            r_ren   <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign waitrequest   = (r_state != IDLE);
  assign readdata      = r_rdata;
  assign readdatavalid = r_rdv;
  assign lb_addr       = r_addr;
  assign lb_wdata      = r_wdata;
  assign lb_wstrb      = r_wstrb;
  assign lb_wen        = r_wen;
  assign lb_ren        = r_ren;
  assign err           = r_err;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_amm2lb.sv
// Directed bench for amm2lb: writes, reads, timeout, collision, back-to-back and reset abort.
module tb_amm2lb;
  import amm2lb_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] address;
  logic        read_s;
  logic        write_s;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic [15:0] lb_addr;
  logic [31:0] lb_wdata;
  logic [3:0]  lb_wstrb;
  logic        lb_wen;
  logic        lb_wready;
  logic        lb_ren;
  logic [31:0] lb_rdata;
  logic        lb_rvalid;
  logic        err;
  state_t      dbg_state;

  logic [31:0] rdata_drv;
  logic [31:0] echo;
  logic        echo_mode;
  int          wr_cnt;
  int          rd_cnt;
  int          checks;
  int          failures;

  amm2lb #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .address(address), .read_s(read_s), .write_s(write_s),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest), .lb_addr(lb_addr),
    .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen), .lb_wready(lb_wready),
    .lb_ren(lb_ren), .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid), .err(err),
    .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Local-bus model: remembers the last completed write and counts completed transfers.
  assign lb_rdata = echo_mode ? echo : rdata_drv;
  always @(posedge clk) begin
    if (reset && lb_wen && lb_wready) begin
      echo   <= lb_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (reset && lb_ren && lb_rvalid) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: hold the request until an edge where waitrequest was low; returns #1 after that edge.
  task automatic amm_req(input logic wr, input logic rd, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    logic acc;
    acc = 1'b0;
    address = a; writedata = d; byteenable = be; write_s = wr; read_s = rd;
    for (int i = 0; i < 50; i++) begin
      acc = !waitrequest;
      tick();
      if (acc) break;
    end
    if (!acc) check("accept_bound", 32'd0, 32'd1);
    write_s = 1'b0; read_s = 1'b0;
  endtask

  initial begin
    int n;
    int w0;
    int r0;
    checks = 0; failures = 0; wr_cnt = 0; rd_cnt = 0;
    echo = '0; echo_mode = 1'b0; rdata_drv = '0;
    reset = 1'b0; address = '0; read_s = 1'b0; write_s = 1'b0;
    writedata = '0; byteenable = '0; lb_wready = 1'b0; lb_rvalid = 1'b0;
    tick(); tick();
    check("rst_wait", 32'(waitrequest), 32'd0);
    check("rst_wen", 32'(lb_wen), 32'd0);
    check("rst_ren", 32'(lb_ren), 32'd0);
    check("rst_rdv", 32'(readdatavalid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;
    tick();

    // 1: single write, ack tied high
    lb_wready = 1'b1;
    amm_req(1'b1, 1'b0, 16'h0010, 32'hA5A5_1234, 4'hF);
    check("t1_wen", 32'(lb_wen), 32'd1);
    check("t1_addr", 32'(lb_addr), 32'h0010);
    check("t1_wdata", lb_wdata, 32'hA5A5_1234);
    check("t1_wstrb", 32'(lb_wstrb), 32'hF);
    check("t1_wait_hi", 32'(waitrequest), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    tick();
    check("t1_wen_lo", 32'(lb_wen), 32'd0);
    check("t1_wait_lo", 32'(waitrequest), 32'd0);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd1);
    lb_wready = 1'b0;

    // 2: read acked on the third cycle of lb_ren
    rdata_drv = 32'h0BAD_F00D;
    amm_req(1'b0, 1'b1, 16'h0024, 32'h0, 4'h0);
    check("t2_addr", 32'(lb_addr), 32'h0024);
    n = 0;
    while (lb_ren && n < 20) begin
      n++;
      if (n == 3) lb_rvalid = 1'b1;
      tick();
    end
    check("t2_ren_cycles", 32'(n), 32'd3);
    check("t2_rdv", 32'(readdatavalid), 32'd1);
    check("t2_rdata", readdata, 32'h0BAD_F00D);
    check("t2_wait_lo", 32'(waitrequest), 32'd0);
    lb_rvalid = 1'b0;
    tick();
    check("t2_rdv_lo", 32'(readdatavalid), 32'd0);
    check("t2_rdata_held", readdata, 32'h0BAD_F00D);

    // 3: read timeout after 8 cycles
    amm_req(1'b0, 1'b1, 16'h0030, 32'h0, 4'h0);
    n = 0;
    while (lb_ren && n < 20) begin
      n++;
      tick();
    end
    check("t3_ren_cycles", 32'(n), 32'd8);
    check("t3_rdv", 32'(readdatavalid), 32'd1);
    check("t3_err", 32'(err), 32'd1);
    check("t3_rdata", readdata, 32'hDEAD_BEEF);
    tick();
    check("t3_err_lo", 32'(err), 32'd0);
    lb_wready = 1'b1;
    amm_req(1'b1, 1'b0, 16'h0034, 32'h0000_0077, 4'h3);
    check("t3_next_wen", 32'(lb_wen), 32'd1);
    check("t3_next_addr", 32'(lb_addr), 32'h0034);
    tick();
    check("t3_next_done", 32'(lb_wen), 32'd0);

    // 5: back-to-back write then read, local side echoes the last write
    echo_mode = 1'b1; lb_rvalid = 1'b1;
    w0 = wr_cnt; r0 = rd_cnt;
    amm_req(1'b1, 1'b0, 16'h0000, 32'h0000_0001, 4'hF);
    amm_req(1'b0, 1'b1, 16'h0000, 32'h0, 4'h0);
    check("t5_ren", 32'(lb_ren), 32'd1);
    tick();
    check("t5_rdv", 32'(readdatavalid), 32'd1);
    check("t5_rdata", readdata, 32'h0000_0001);
    check("t5_wr_once", 32'(wr_cnt - w0), 32'd1);
    check("t5_rd_once", 32'(rd_cnt - r0), 32'd1);
    lb_rvalid = 1'b0; echo_mode = 1'b0;
    tick();

    // 4: simultaneous read and write
    w0 = wr_cnt; r0 = rd_cnt;
    amm_req(1'b1, 1'b1, 16'h0004, 32'h0000_0044, 4'hF);
    check("t4_wen", 32'(lb_wen), 32'd1);
    check("t4_ren", 32'(lb_ren), 32'd0);
    check("t4_addr", 32'(lb_addr), 32'h0004);
    check("t4_err", 32'(err), 32'd1);
    check("t4_rdv", 32'(readdatavalid), 32'd1);
    check("t4_rdata", readdata, 32'hDEAD_BEEF);
    tick();
    check("t4_err_lo", 32'(err), 32'd0);
    check("t4_rdv_lo", 32'(readdatavalid), 32'd0);
    check("t4_one_write", 32'(wr_cnt - w0), 32'd1);
    check("t4_no_read", 32'(rd_cnt - r0), 32'd0);

    // 6: reset while a read is outstanding
    lb_wready = 1'b0;
    amm_req(1'b0, 1'b1, 16'h000C, 32'h0, 4'h0);
    tick();
    check("t6_ren_pre", 32'(lb_ren), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_ren_async", 32'(lb_ren), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(IDLE));
    tick();
    check("t6_no_rdv", 32'(readdatavalid), 32'd0);
    reset = 1'b1;
    tick();
    check("t6_no_rdv2", 32'(readdatavalid), 32'd0);
    lb_wready = 1'b1;
    amm_req(1'b1, 1'b0, 16'h0008, 32'h0000_0055, 4'hF);
    check("t6_w_addr", 32'(lb_addr), 32'h0008);
    check("t6_w_data", lb_wdata, 32'h0000_0055);
    tick();
    check("t6_w_done", 32'(lb_wen), 32'd0);
    check("t6_w_echo", echo, 32'h0000_0055);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
